// File: rtl/el_uart_tx.sv
`timescale 1ns / 1ps
// el_uart_tx: 8-bit asynchronous serial transmitter (start + 8 data LSB-first + stop).
// Bytes are accepted over valid/ready into a one-byte holding register. Frames go out
// back-to-back with no idle gap whenever the holding register is refilled in time.
//
// Parameters
//   CLKS_PER_BIT   clock cycles per serial bit, legal range 2..255
// Configuration
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between data and stop (8E1);
//                      otherwise the frame is 8N1.
// Ports
//   in_main_clock  system clock, all state on posedge
//   in_reset_n     asynchronous active-low reset
//   in_tx_valid    producer offers in_tx_data
//   in_tx_data     byte to send, bit 0 first
//   out_tx_ready   holding register empty
//   out_tx_serial  serial line, idles high
//   out_tx_busy    high whenever the FSM is not idle
//   out_tx_done    one-cycle pulse on the last clock of each stop bit
module el_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 231
) (
  input  logic       in_main_clock,
  input  logic       in_reset_n,
  input  logic       in_tx_valid,
  input  logic [7:0] in_tx_data,
  output logic       out_tx_ready,
  output logic       out_tx_serial,
  output logic       out_tx_busy,
  output logic       out_tx_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] DoneCnt = CntW'(CLKS_PER_BIT - 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e            r_state;
  logic [CntW-1:0]   r_clk_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic [7:0]        r_hold;
  logic              r_tx_ready;  // doubles as "holding register empty"
  logic              r_serial;
  logic              r_busy;
  logic              r_done;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  logic w_bit_end;
  logic w_load;

  assign w_bit_end = (r_clk_cnt == LastCnt);
  // Hold-to-shift transfer: from idle, or on the last stop cycle for a gapless next frame.
  assign w_load    = !r_tx_ready &&
                     ((r_state == StIdle) || ((r_state == StStop) && w_bit_end));

  always_ff @(posedge in_main_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state    <= StIdle;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_hold     <= '0;
      r_tx_ready <= 1'b1;
      r_serial   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

      case (r_state)
        StIdle: begin
          if (w_load) begin
            r_clk_cnt <= '0;
            r_serial  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= StStart;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_serial  <= r_shift[0];
            r_state   <= StData;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_serial <= r_parity;
              r_state  <= StParity;
`else
              r_serial <= 1'b1;
              r_state  <= StStop;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_serial  <= r_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_serial  <= 1'b1;
            r_state   <= StStop;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`endif
        StStop: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (w_load) begin
              r_serial <= 1'b0;
              r_state  <= StStart;
            end else begin
              r_serial <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= StIdle;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
            // Registered pulse: raise it one cycle early so it lands on the last stop clock.
            r_done    <= (r_clk_cnt == DoneCnt);
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase

      if (w_load) begin
        r_shift    <= r_hold;
        r_tx_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
        r_parity   <= ^r_hold;
`endif
      end

      // Accept and transfer are exclusive: accept needs the hold empty, transfer needs it full.
      if (in_tx_valid && r_tx_ready) begin
        r_hold     <= in_tx_data;
        r_tx_ready <= 1'b0;
      end
    end
  end

  assign out_tx_ready  = r_tx_ready;
  assign out_tx_serial = r_serial;
  assign out_tx_busy   = r_busy;
  assign out_tx_done   = r_done;

endmodule

// File: tb/tb_el_uart_tx.sv
`timescale 1ns / 1ps
// Testbench for el_uart_tx with CLKS_PER_BIT=4: directed frame checks plus a randomized
// byte stream decoded by a behavioural serial receiver and compared with a byte queue.
module tb_el_uart_tx;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int F = FrameBits * CPB;

  logic       in_main_clock = 1'b0;
  logic       in_reset_n    = 1'b0;
  logic       in_tx_valid   = 1'b0;
  logic [7:0] in_tx_data    = 8'h00;
  logic       out_tx_ready;
  logic       out_tx_serial;
  logic       out_tx_busy;
  logic       out_tx_done;

  int n_checks = 0;
  int n_fails  = 0;
  int rx_count = 0;
  int tx_count = 0;
  logic rx_en   = 1'b0;
  logic rx_busy = 1'b0;
  logic [7:0] exp_q[$];

  el_uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
    .in_main_clock (in_main_clock),
    .in_reset_n    (in_reset_n),
    .in_tx_valid   (in_tx_valid),
    .in_tx_data    (in_tx_data),
    .out_tx_ready  (out_tx_ready),
    .out_tx_serial (out_tx_serial),
    .out_tx_busy   (out_tx_busy),
    .out_tx_done   (out_tx_done)
  );

  always #5 in_main_clock = ~in_main_clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge in_main_clock);
    #1;
  endtask

  // Expected line level at cycle c (0-based) of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int c);
    int j;
    j = c / CPB;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // From idle: offer b for one edge, then follow the whole frame cycle by cycle.
  task automatic send_and_check(input string tag, input logic [7:0] b);
    int line_err = 0;
    int busy_err = 0;
    int done_n   = 0;
    int done_k   = 0;
    in_tx_valid = 1'b1;
    in_tx_data  = b;
    step();
    in_tx_valid = 1'b0;
    in_tx_data  = 8'($urandom);
    for (int k = 1; k <= F + 1; k++) begin
      step();
      if (out_tx_serial !== ((k <= F) ? frame_bit(b, k - 1) : 1'b1)) line_err++;
      if (out_tx_busy !== logic'(k <= F)) busy_err++;
      if (out_tx_done === 1'b1) begin
        done_n++;
        done_k = k;
      end
    end
    check_eq($sformatf("%s_line", tag), line_err, 0);
    check_eq($sformatf("%s_busy", tag), busy_err, 0);
    check_eq($sformatf("%s_done_n", tag), done_n, 1);
    check_eq($sformatf("%s_done_cyc", tag), done_k, F);
  endtask

  // Offer b until accepted (bounded); accepted bytes go to the receiver's queue.
  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    in_tx_valid = 1'b1;
    in_tx_data  = b;
    while (out_tx_ready !== 1'b1 && t < 3 * F) begin
      step();
      t++;
    end
    check_eq("push_ready", out_tx_ready, 1);
    if (out_tx_ready === 1'b1) begin
      step();
      exp_q.push_back(b);
      tx_count++;
    end
    in_tx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || rx_busy || out_tx_busy) && t < 40 * F) begin
      step();
      t++;
    end
    check_eq($sformatf("%s_q_empty", tag), exp_q.size(), 0);
    check_eq($sformatf("%s_rx_count", tag), rx_count, tx_count);
  endtask

  // Behavioural receiver: mid-bit sampling from the first start-bit cycle.
  initial begin : rx_model
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(posedge in_main_clock);
      #2;
      if (rx_en && out_tx_serial === 1'b0) begin
        rx_busy = 1'b1;
        repeat (CPB / 2) @(posedge in_main_clock);
        #2;
        check_eq("rx_start", out_tx_serial, 0);
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(posedge in_main_clock);
          #2;
          b[j] = out_tx_serial;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(posedge in_main_clock);
        #2;
        check_eq("rx_parity", out_tx_serial, ^b);
`endif
        repeat (CPB) @(posedge in_main_clock);
        #2;
        check_eq("rx_stop", out_tx_serial, 1);
        repeat (CPB - CPB / 2 - 1) @(posedge in_main_clock);
        #2;
        check_eq("rx_done", out_tx_done, 1);
        check_eq("rx_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rx_byte", b, e);
        end
        rx_count++;
        rx_busy = 1'b0;
      end
    end
  end

  initial begin : main
    int errs;
    int r_err, b_err, done_n, d1, d2;
    int gap;
    logic exp_l;

    // Reset held for 5 cycles, then the first cycle after release.
    errs = 0;
    repeat (5) begin
      step();
      if ({out_tx_serial, out_tx_ready, out_tx_busy, out_tx_done} !== 4'b1100) errs++;
    end
    check_eq("reset_outputs", errs, 0);
    in_reset_n = 1'b1;
    step();
    check_eq("post_reset_outputs",
             {out_tx_serial, out_tx_ready, out_tx_busy, out_tx_done}, 4'b1100);

    send_and_check("a5", 8'hA5);

    // Valid held high: 0x00 then 0xFF, gapless frames.
    in_tx_valid = 1'b1;
    in_tx_data  = 8'h00;
    step();
    in_tx_data  = 8'hFF;
    errs = 0; r_err = 0; b_err = 0; done_n = 0; d1 = 0; d2 = 0;
    for (int k = 1; k <= 2 * F + 2; k++) begin
      step();
      if (k == 2) in_tx_valid = 1'b0;
      exp_l = (k <= F) ? frame_bit(8'h00, k - 1) :
              (k <= 2 * F) ? frame_bit(8'hFF, k - 1 - F) : 1'b1;
      if (out_tx_serial !== exp_l) errs++;
      if (out_tx_ready !== logic'((k == 1) || (k > F))) r_err++;
      if (out_tx_busy !== logic'(k <= 2 * F)) b_err++;
      if (out_tx_done === 1'b1) begin
        done_n++;
        if (done_n == 1) d1 = k;
        else d2 = k;
      end
    end
    check_eq("b2b_line", errs, 0);
    check_eq("b2b_ready", r_err, 0);
    check_eq("b2b_busy", b_err, 0);
    check_eq("b2b_done_n", done_n, 2);
    check_eq("b2b_done_gap", d2 - d1, F);

    // Reset during data bit 3 of 0x5A with 0x99 pending in the hold.
    in_tx_valid = 1'b1;
    in_tx_data  = 8'h5A;
    step();
    in_tx_data  = 8'h99;
    step();
    step();
    in_tx_valid = 1'b0;
    repeat (16) step();
    check_eq("pre_rst_bit3", out_tx_serial, frame_bit(8'h5A, 17));
    check_eq("pre_rst_ready", out_tx_ready, 0);
    in_reset_n = 1'b0;
    #1;
    check_eq("async_rst_outputs",
             {out_tx_serial, out_tx_ready, out_tx_busy, out_tx_done}, 4'b1100);
    repeat (3) step();
    in_reset_n = 1'b1;
    step();
    send_and_check("after_rst_3c", 8'h3C);

`ifdef UART_TX_PARITY_EN
    send_and_check("par_07", 8'h07);
    send_and_check("par_03", 8'h03);
`endif

    // Data changed while valid waits on a full hold: 0x22 goes out, 0x11 never does.
    rx_en = 1'b1;
    push_byte(8'h00);
    push_byte(8'hAA);
    in_tx_valid = 1'b1;
    in_tx_data  = 8'h11;
    repeat (10) step();
    check_eq("hold_full_ready", out_tx_ready, 0);
    push_byte(8'h22);
    drain("swap");

    // Randomized stream with a mix of gapless and idle-separated bytes.
    for (int i = 0; i < 24; i++) begin
      gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : 0;
      repeat (gap) step();
      push_byte(8'($urandom));
    end
    drain("rand");
    check_eq("final_idle", {out_tx_serial, out_tx_ready, out_tx_busy}, 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
